// File: rtl/k051937_sprite_feeder_pkg.sv
// Shared sprite-interface constants, FSM state codes and size/cost helpers
// for the k051937 sprite attribute feeder.
package k051937_sprite_feeder_pkg;

  localparam int unsigned LINE_BUDGET_DEF = 768;
  localparam int unsigned CHUNK_CYC       = 4;

  localparam int unsigned BUDGET_W = 10;
  localparam int unsigned X_W      = 9;
  localparam int unsigned COLOR_W  = 8;
  localparam int unsigned SIZE_W   = 2;
  localparam int unsigned CIDX_W   = 4;
  localparam int unsigned NCH_W    = 5;
  localparam int unsigned PHASE_W  = 2;

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CHUNK_CYC - 1);
  localparam logic [PHASE_W-1:0] PHASE_PRE  = PHASE_W'(CHUNK_CYC - 2);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LATCH = 3'd2;
  localparam logic [2:0] ST_CHUNK = 3'd3;
  localparam logic [2:0] ST_END   = 3'd4;

  typedef struct packed {
    logic [X_W-1:0]     x;
    logic [COLOR_W-1:0] color;
    logic               flip;
  } spr_attr_t;

  // Width code 0..3 -> 2/4/8/16 chunks of 8 pixels.
  function automatic logic [NCH_W-1:0] nch_of(input logic [SIZE_W-1:0] size);
    return NCH_W'(2) << size;
  endfunction

  // One LACH cycle plus CHUNK_CYC cycles per chunk.
  function automatic logic [BUDGET_W-1:0] cost_of(input logic [SIZE_W-1:0] size);
    return BUDGET_W'(1 + CHUNK_CYC * nch_of(size));
  endfunction

endpackage

// File: rtl/k051937_sprite_feeder_if.sv
// Sprite queue handshake plus line-buffer attribute bus of the feeder.
interface k051937_sprite_feeder_if;
  import k051937_sprite_feeder_pkg::*;

  logic               LINE_START;
  logic               SPR_VALID;
  logic               SPR_READY;
  logic [X_W-1:0]     SPR_X;
  logic [COLOR_W-1:0] SPR_COLOR;
  logic               SPR_FLIP;
  logic [SIZE_W-1:0]  SPR_SIZE;
  logic [X_W-1:0]     HP;
  logic [COLOR_W-1:0] OC;
  logic               OHF;
  logic               LACH;
  logic               CARY;
  logic               HEND;
  logic               FETCH_STB;
  logic [CIDX_W-1:0]  CHUNK_IDX;
  logic               BUSY;

  modport master (
    input  LINE_START, SPR_VALID, SPR_X, SPR_COLOR, SPR_FLIP, SPR_SIZE,
    output SPR_READY, HP, OC, OHF, LACH, CARY, HEND, FETCH_STB, CHUNK_IDX, BUSY
  );

  modport slave (
    output LINE_START, SPR_VALID, SPR_X, SPR_COLOR, SPR_FLIP, SPR_SIZE,
    input  SPR_READY, HP, OC, OHF, LACH, CARY, HEND, FETCH_STB, CHUNK_IDX, BUSY
  );

endinterface

// File: rtl/k051937_feeder_budget.sv
// Per-line render-cycle budget: load on line start, count down while busy,
// saturate at zero, and report whether a sprite cost still fits.
module k051937_feeder_budget
  import k051937_sprite_feeder_pkg::*;
#(
  parameter int unsigned LINE_BUDGET = LINE_BUDGET_DEF
) (
  input  logic                clk_12M,
  input  logic                RES,
  input  logic                load,
  input  logic                dec,
  input  logic [BUDGET_W-1:0] cost,
  output logic [BUDGET_W-1:0] count,
  output logic                fits_c
);

  always_ff @(posedge clk_12M or posedge RES) begin
    if (RES) begin
      count <= '0;
    end else if (load) begin
      count <= BUDGET_W'(LINE_BUDGET);
    end else if (dec && (count != '0)) begin
      count <= count - BUDGET_W'(1);
    end
  end

  assign fits_c = (count >= cost);

endmodule

// File: rtl/k051937_sprite_feeder.sv
// Sprite attribute feeder: pops sorted sprites once per line, sequences
// LACH + chunk slots toward the line buffer and issues ROM chunk fetches.
module k051937_sprite_feeder
  import k051937_sprite_feeder_pkg::*;
#(
  parameter int unsigned LINE_BUDGET = LINE_BUDGET_DEF
) (
  input  logic                      clk_12M,
  input  logic                      RES,
  k051937_sprite_feeder_if.master   bus
);

  logic [2:0]          state, state_n;
  logic [PHASE_W-1:0]  phase, phase_n;
  logic [CIDX_W-1:0]   chunk, chunk_n;
  logic [NCH_W-1:0]    nch, nch_n;
  spr_attr_t           attr_q, attr_n;
  logic [CIDX_W-1:0]   idx_q, idx_n;
  logic                lach_q, lach_n;
  logic                cary_q, cary_n;
  logic                hend_q, hend_n;
  logic                stb_q, stb_n;
  logic                busy_q;
  logic                load_c;
  logic                ready_c;
  logic                fits_c;
  logic                last_chunk_c;
  logic [BUDGET_W-1:0] cost_c;
  logic [BUDGET_W-1:0] budget;

  // Fetch order is reversed for horizontally flipped sprites.
  function automatic logic [CIDX_W-1:0] chunk_idx(input logic flip,
                                                  input logic [NCH_W-1:0] n,
                                                  input logic [CIDX_W-1:0] c);
    return flip ? (CIDX_W'(n - NCH_W'(1)) - c) : c;
  endfunction

  assign cost_c       = cost_of(bus.SPR_SIZE);
  assign last_chunk_c = (chunk == CIDX_W'(nch - NCH_W'(1)));

  k051937_feeder_budget #(
    .LINE_BUDGET (LINE_BUDGET)
  ) u_budget (
    .clk_12M (clk_12M),
    .RES     (RES),
    .load    (load_c),
    .dec     (state != ST_IDLE),
    .cost    (cost_c),
    .count   (budget),
    .fits_c  (fits_c)
  );

  // Next state and next registered outputs; LINE_START overrides everything.
  always_comb begin
    state_n = state;
    phase_n = phase;
    chunk_n = chunk;
    nch_n   = nch;
    attr_n  = attr_q;
    idx_n   = idx_q;
    lach_n  = 1'b0;
    cary_n  = 1'b0;
    hend_n  = 1'b0;
    stb_n   = 1'b0;
    load_c  = 1'b0;
    ready_c = 1'b0;

    if (bus.LINE_START) begin
      load_c  = 1'b1;
      state_n = ST_FETCH;
      // END already carries this line's HEND pulse.
      hend_n  = (state != ST_IDLE) && (state != ST_END);
    end else begin
      case (state)
        ST_IDLE: begin
        end
        ST_FETCH: begin
          if (bus.SPR_VALID && fits_c) begin
            ready_c      = 1'b1;
            attr_n.x     = bus.SPR_X;
            attr_n.color = bus.SPR_COLOR;
            attr_n.flip  = bus.SPR_FLIP;
            nch_n        = nch_of(bus.SPR_SIZE);
            lach_n       = 1'b1;
            state_n      = ST_LATCH;
          end else begin
            hend_n  = 1'b1;
            state_n = ST_END;
          end
        end
        ST_LATCH: begin
          state_n = ST_CHUNK;
          phase_n = '0;
          chunk_n = '0;
          stb_n   = 1'b1;
          idx_n   = chunk_idx(attr_q.flip, nch, '0);
        end
        ST_CHUNK: begin
          if (phase == PHASE_LAST) begin
            if (last_chunk_c) begin
              state_n = ST_FETCH;
            end else begin
              chunk_n = chunk + CIDX_W'(1);
              phase_n = '0;
              stb_n   = 1'b1;
              idx_n   = chunk_idx(attr_q.flip, nch, chunk + CIDX_W'(1));
            end
          end else begin
            phase_n = phase + PHASE_W'(1);
            cary_n  = (phase == PHASE_PRE) && !last_chunk_c;
          end
        end
        ST_END: begin
          state_n = ST_IDLE;
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_12M or posedge RES) begin
    if (RES) begin
      state  <= ST_IDLE;
      phase  <= '0;
      chunk  <= '0;
      nch    <= '0;
      attr_q <= '0;
      idx_q  <= '0;
      lach_q <= 1'b0;
      cary_q <= 1'b0;
      hend_q <= 1'b0;
      stb_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_n;
      phase  <= phase_n;
      chunk  <= chunk_n;
      nch    <= nch_n;
      attr_q <= attr_n;
      idx_q  <= idx_n;
      lach_q <= lach_n;
      cary_q <= cary_n;
      hend_q <= hend_n;
      stb_q  <= stb_n;
      busy_q <= (state_n != ST_IDLE);
    end
  end

  assign bus.SPR_READY = ready_c;
  assign bus.HP        = attr_q.x;
  assign bus.OC        = attr_q.color;
  assign bus.OHF       = attr_q.flip;
  assign bus.LACH      = lach_q;
  assign bus.CARY      = cary_q;
  assign bus.HEND      = hend_q;
  assign bus.FETCH_STB = stb_q;
  assign bus.CHUNK_IDX = idx_q;
  assign bus.BUSY      = busy_q;

endmodule
